// File: rtl/exe_unit_arbiter.sv
// Two-requester arbiter in front of a single exe unit: req/gnt/done handshake, round-robin on ties.
// Define EXE_ARB_FIXED_PRIO_EN to make requester 0 always win a tie instead.
module exe_unit_arbiter #(
  parameter int m   = 4,
  parameter int n   = 2,
  parameter int LAT = 1
) (
  input  logic         i_clk,
  input  logic         i_rsn,
  input  logic [1:0]   i_req,
  input  logic [n-1:0] i_oper0,
  input  logic [m-1:0] i_argA0,
  input  logic [m-1:0] i_argB0,
  input  logic [n-1:0] i_oper1,
  input  logic [m-1:0] i_argA1,
  input  logic [m-1:0] i_argB1,
  output logic [1:0]   o_gnt,
  output logic [1:0]   o_done,
  output logic         o_busy,
  output logic [m-1:0] o_result,
  output logic [3:0]   o_status,
  output logic [n-1:0] o_exe_oper,
  output logic [m-1:0] o_exe_argA,
  output logic [m-1:0] o_exe_argB,
  input  logic [m-1:0] i_exe_result,
  input  logic [3:0]   i_exe_status
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_e;

  localparam logic [3:0] LAT_C = 4'(LAT);

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         last_q, last_d;
  logic         win;
  logic [1:0]   gnt_q, gnt_d;
  logic [1:0]   done_q, done_d;
  logic         busy_q, busy_d;
  logic [m-1:0] result_q, result_d;
  logic [3:0]   status_q, status_d;
  logic [n-1:0] exe_oper_q, exe_oper_d;
  logic [m-1:0] exe_arga_q, exe_arga_d;
  logic [m-1:0] exe_argb_q, exe_argb_d;

  // last_q is both the round-robin pointer and the owner of the op in flight
  always_comb begin
`ifdef EXE_ARB_FIXED_PRIO_EN
    win = ~i_req[0];
`else
    win = (i_req == 2'b11) ? ~last_q : i_req[1];
`endif
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    gnt_d      = 2'b00;
    done_d     = 2'b00;
    busy_d     = busy_q;
    result_d   = result_q;
    status_d   = status_q;
    exe_oper_d = exe_oper_q;
    exe_arga_d = exe_arga_q;
    exe_argb_d = exe_argb_q;
    case (state_q)
      IDLE: begin
        if (|i_req) begin
          gnt_d      = win ? 2'b10 : 2'b01;
          exe_oper_d = win ? i_oper1 : i_oper0;
          exe_arga_d = win ? i_argA1 : i_argA0;
          exe_argb_d = win ? i_argB1 : i_argB0;
          busy_d     = 1'b1;
          cnt_d      = 4'd0;
          last_d     = win;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAT_C) begin
          result_d = i_exe_result;
          status_d = i_exe_status;
          done_d   = last_q ? 2'b10 : 2'b01;
          state_d  = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rsn) begin
    if (i_rsn) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      last_q     <= 1'b1;
      gnt_q      <= 2'b00;
      done_q     <= 2'b00;
      busy_q     <= 1'b0;
      result_q   <= '0;
      status_q   <= 4'b0000;
      exe_oper_q <= '0;
      exe_arga_q <= '0;
      exe_argb_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      result_q   <= result_d;
      status_q   <= status_d;
      exe_oper_q <= exe_oper_d;
      exe_arga_q <= exe_arga_d;
      exe_argb_q <= exe_argb_d;
    end
  end

  assign o_gnt      = gnt_q;
  assign o_done     = done_q;
  assign o_busy     = busy_q;
  assign o_result   = result_q;
  assign o_status   = status_q;
  assign o_exe_oper = exe_oper_q;
  assign o_exe_argA = exe_arga_q;
  assign o_exe_argB = exe_argb_q;

endmodule

// File: tb/tb_exe_unit_arbiter.sv
// Bench for exe_unit_arbiter with an adder exe stub (LAT=1); transaction-level model of the
// arbitration and handshake, directed steps followed by randomized requests.
module tb_exe_unit_arbiter;

   localparam int M   = 4;
   localparam int N   = 2;
   localparam int LAT = 1;

   logic clk = 1'b0;
   logic rst;
   logic [1:0]   req;
   logic [N-1:0] oper0, oper1;
   logic [M-1:0] argA0, argB0, argA1, argB1;
   logic [1:0]   gnt, done;
   logic         busy;
   logic [M-1:0] result;
   logic [3:0]   status;
   logic [N-1:0] exeOper;
   logic [M-1:0] exeArgA, exeArgB;
   logic [M-1:0] stubResult;
   logic [3:0]   stubStatus;

   int checks = 0;
   int failures = 0;
   int lastWin = 1;
   logic [1:0]   pend;
   logic [N-1:0] opOf [2];
   logic [M-1:0] aOf [2];
   logic [M-1:0] bOf [2];

   exe_unit_arbiter #(.m(M), .n(N), .LAT(LAT)) dut (
      .i_clk(clk), .i_rsn(rst), .i_req(req),
      .i_oper0(oper0), .i_argA0(argA0), .i_argB0(argB0),
      .i_oper1(oper1), .i_argA1(argA1), .i_argB1(argB1),
      .o_gnt(gnt), .o_done(done), .o_busy(busy),
      .o_result(result), .o_status(status),
      .o_exe_oper(exeOper), .o_exe_argA(exeArgA), .o_exe_argB(exeArgB),
      .i_exe_result(stubResult), .i_exe_status(stubStatus)
   );

   always #5 clk = ~clk;

   // exe unit stand-in: one-cycle registered adder with a fixed status
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stubResult <= '0;
         stubStatus <= 4'h0;
      end else begin
         stubResult <= exeArgA + exeArgB;
         stubStatus <= 4'hA;
      end
   end

   // compare one observed value against its expectation, counting checks and failures
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus();
      req   = pend;
      oper0 = opOf[0];
      argA0 = aOf[0];
      argB0 = bOf[0];
      oper1 = opOf[1];
      argA1 = aOf[1];
      argB1 = bOf[1];
   endtask

   task automatic setRequest(input int r);
      pend[r] = 1'b1;
      opOf[r] = N'($urandom);
      aOf[r]  = M'($urandom);
      bOf[r]  = M'($urandom);
   endtask

   function automatic int expWinner(input logic [1:0] p);
      if (p == 2'b11) begin
`ifdef EXE_ARB_FIXED_PRIO_EN
         return 0;
`else
         return 1 - lastWin;
`endif
      end
      return p[0] ? 0 : 1;
   endfunction

   // One full operation starting in an IDLE cycle; raiseMask adds requests during WAIT
   task automatic runTransaction(input logic [1:0] raiseMask);
      int w;
      int waitCycles;
      logic [1:0]   expGnt;
      logic [N-1:0] expOp;
      logic [M-1:0] expA, expB, expRes;
      applyStimulus();
      w      = expWinner(pend);
      expGnt = (w == 1) ? 2'b10 : 2'b01;
      expOp  = opOf[w];
      expA   = aOf[w];
      expB   = bOf[w];
      expRes = aOf[w] + bOf[w];
      waitCycles = 0;
      do begin
         tick();
         waitCycles++;
      end while (gnt == 2'b00 && waitCycles < 4);
      checkOutput("gnt_latency", waitCycles, 1);
      checkOutput("gnt", gnt, expGnt);
      checkOutput("busy_gnt", busy, 1'b1);
      checkOutput("exe_oper", exeOper, expOp);
      checkOutput("exe_argA", exeArgA, expA);
      checkOutput("exe_argB", exeArgB, expB);
      lastWin = w;
      pend[w] = 1'b0;
      aOf[w]  = aOf[w] ^ M'(4);
      for (int r = 0; r < 2; r++)
         if (raiseMask[r] && !pend[r]) setRequest(r);
      applyStimulus();
      for (int i = 0; i < LAT; i++) begin
         tick();
         checkOutput("gnt_pulse", gnt, 2'b00);
         checkOutput("early_done", done, 2'b00);
         checkOutput("hold_argA", exeArgA, expA);
      end
      tick();
      checkOutput("done", done, expGnt);
      checkOutput("result", result, expRes);
      checkOutput("status", status, 4'hA);
      checkOutput("busy_done", busy, 1'b1);
      tick();
      checkOutput("done_pulse", done, 2'b00);
      checkOutput("busy_idle", busy, 1'b0);
      checkOutput("result_held", result, expRes);
   endtask

   initial begin
      rst  = 1'b1;
      pend = 2'b00;
      for (int r = 0; r < 2; r++) begin
         opOf[r] = '0;
         aOf[r]  = '0;
         bOf[r]  = '0;
      end
      applyStimulus();
      tick();
      tick();
      $display("[TB] reset state");
      checkOutput("rst_gnt", gnt, 2'b00);
      checkOutput("rst_done", done, 2'b00);
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_result", result, 4'h0);
      checkOutput("rst_status", status, 4'h0);
      checkOutput("rst_exe_argA", exeArgA, 4'h0);
      rst = 1'b0;
      tick();

      $display("[TB] ties alternate after reset");
      for (int k = 0; k < 3; k++) begin
         if (!pend[0]) setRequest(0);
         if (!pend[1]) setRequest(1);
         runTransaction(2'b00);
      end
      pend = 2'b00;

      $display("[TB] single request with operand hold");
      opOf[0] = 2'b00;
      aOf[0]  = 4'b0111;
      bOf[0]  = 4'b0001;
      pend    = 2'b01;
      runTransaction(2'b00);

      $display("[TB] request deferred during WAIT");
      setRequest(0);
      runTransaction(2'b10);
      runTransaction(2'b00);

      $display("[TB] reset mid-operation");
      setRequest(0);
      applyStimulus();
      tick();
      checkOutput("midrst_gnt", gnt, 2'b01);
      pend = 2'b00;
      applyStimulus();
      tick();
      rst = 1'b1;
      #1;
      checkOutput("midrst_busy", busy, 1'b0);
      checkOutput("midrst_done", done, 2'b00);
      checkOutput("midrst_result", result, 4'h0);
      checkOutput("midrst_status", status, 4'h0);
      checkOutput("midrst_exe_argA", exeArgA, 4'h0);
      checkOutput("midrst_exe_oper", exeOper, 2'b00);
      lastWin = 1;
      tick();
      rst = 1'b0;
      tick();
      checkOutput("postrst_done", done, 2'b00);
      tick();
      checkOutput("postrst_done2", done, 2'b00);
      setRequest(0);
      setRequest(1);
      runTransaction(2'b00);
      pend = 2'b00;

      $display("[TB] randomized requests");
      for (int it = 0; it < 30; it++) begin
         for (int r = 0; r < 2; r++)
            if (!pend[r] && $urandom_range(0, 1) == 1) setRequest(r);
         if (pend == 2'b00) setRequest(int'($urandom_range(0, 1)));
         runTransaction(2'($urandom_range(0, 3)));
      end

      $display("[TB] TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
